// File: rtl/vdp_pkg.sv
// Shared types and constants for the VDP CPU port: VRAM access FSM states,
// status bit positions and the R1 interrupt-enable bit.
package vdp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } vram_state_t;

    localparam int STAT_F     = 7;
    localparam int STAT_5S    = 6;
    localparam int STAT_C     = 5;
    localparam int R1_IE      = 5;
    localparam int ADDR_W_DEF = 14;

endpackage

// File: rtl/vdp_status_reg.sv
// VDP status register: F / 5S / C flags with set-over-clear priority,
// fifth-sprite number capture and the registered interrupt output.
module vdp_status_reg
    import vdp_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       vblank_set,
    input  logic       coll_set,
    input  logic       fifth_set,
    input  logic [4:0] fifth_num,
    input  logic       ie,
    output logic [7:0] status,
    output logic       irq
);

    logic [7:0] status_nx;

    // Sets are applied after the read-clear so a coincident pulse survives.
    always_comb begin
        status_nx = status;
        if (clr) begin
            status_nx[STAT_F]  = 1'b0;
            status_nx[STAT_5S] = 1'b0;
            status_nx[STAT_C]  = 1'b0;
        end
        if (vblank_set) status_nx[STAT_F] = 1'b1;
        if (coll_set)   status_nx[STAT_C] = 1'b1;
        if (fifth_set) begin
            status_nx[STAT_5S] = 1'b1;
            if (!status[STAT_5S]) status_nx[4:0] = fifth_num;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            status <= 8'h00;
            irq    <= 1'b0;
        end else begin
            status <= status_nx;
            irq    <= status[STAT_F] & ie;
        end
    end

endmodule

// File: rtl/vdp_cpu_port.sv
// TMS9918-style CPU port: decodes data/control strobes into register writes,
// VRAM address setup, VRAM read/write requests and status reads.
module vdp_cpu_port
    import vdp_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              pxclk,
    input  logic              reset,
    input  logic              cpu_wr,
    input  logic              cpu_rd,
    input  logic              cpu_mode,
    input  logic [7:0]        cpu_din,
    output logic [7:0]        cpu_dout,
    output logic              cpu_wait,
    output logic [ADDR_W-1:0] vram_addr,
    output logic [7:0]        vram_wdata,
    output logic              vram_we,
    output logic              vram_req,
    input  logic              vram_ack,
    input  logic [7:0]        vram_rdata,
    input  logic              vblank_set,
    input  logic              coll_set,
    input  logic              fifth_set,
    input  logic [4:0]        fifth_num,
    output logic [63:0]       regs,
    output logic              irq
);

    vram_state_t       state, state_nx;
    logic              latch;
    logic [7:0]        lo;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        rbuf;
    logic [7:0]        status;

    logic              idle, rd_ev, ctrl_wr, first_byte, reg_wr, addr_set;
    logic              data_wr, data_rd, stat_rd, issue_wr, issue_rd;
    logic [ADDR_W-1:0] set_addr, issue_addr;

    // A simultaneous write masks the read; data-port and address-setting
    // strobes are only honoured while no VRAM access is outstanding.
    assign idle       = (state == ST_IDLE);
    assign rd_ev      = cpu_rd & ~cpu_wr;
    assign ctrl_wr    = cpu_wr & cpu_mode;
    assign first_byte = ctrl_wr & ~latch;
    assign reg_wr     = ctrl_wr & latch & cpu_din[7];
    assign addr_set   = ctrl_wr & latch & ~cpu_din[7] & idle;
    assign data_wr    = cpu_wr & ~cpu_mode & idle;
    assign data_rd    = rd_ev & ~cpu_mode & idle;
    assign stat_rd    = rd_ev & cpu_mode;
    assign issue_wr   = data_wr;
    assign issue_rd   = data_rd | (addr_set & ~cpu_din[6]);
    assign set_addr   = ADDR_W'({cpu_din[5:0], lo});
    assign issue_addr = addr_set ? set_addr : addr;

    always_ff @(posedge pxclk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        vram_req = 1'b0;
        cpu_wait = 1'b0;
        case (state)
            ST_IDLE: begin
                if (issue_wr)      state_nx = ST_WR;
                else if (issue_rd) state_nx = ST_RD;
            end
            ST_RD, ST_WR: begin
                vram_req = 1'b1;
                cpu_wait = 1'b1;
                if (vram_ack) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge pxclk) begin
        if (reset) begin
            latch      <= 1'b0;
            lo         <= 8'h00;
            addr       <= '0;
            rbuf       <= 8'h00;
            cpu_dout   <= 8'h00;
            regs       <= 64'h0;
            vram_addr  <= '0;
            vram_wdata <= 8'h00;
            vram_we    <= 1'b0;
        end else begin
            if (first_byte) begin
                lo    <= cpu_din;
                latch <= 1'b1;
            end
            if (reg_wr) begin
                regs[{cpu_din[2:0], 3'b000} +: 8] <= lo;
                latch <= 1'b0;
            end
            // A read setup prefetches, so the pointer moves past the fetched byte.
            if (addr_set) begin
                latch <= 1'b0;
                addr  <= cpu_din[6] ? set_addr : set_addr + ADDR_W'(1);
            end
            if (data_wr || data_rd) begin
                latch <= 1'b0;
                addr  <= addr + ADDR_W'(1);
            end
            if (data_wr) rbuf <= cpu_din;
            if (data_rd) cpu_dout <= rbuf;
            if (stat_rd) begin
                cpu_dout <= status;
                latch    <= 1'b0;
            end
            if (issue_wr || issue_rd) begin
                vram_addr  <= issue_addr;
                vram_wdata <= cpu_din;
                vram_we    <= issue_wr;
            end
            if (state == ST_RD && vram_ack) rbuf <= vram_rdata;
        end
    end

    vdp_status_reg u_status (
        .clk        (pxclk),
        .reset      (reset),
        .clr        (stat_rd),
        .vblank_set (vblank_set),
        .coll_set   (coll_set),
        .fifth_set  (fifth_set),
        .fifth_num  (fifth_num),
        .ie         (regs[8 + R1_IE]),
        .status     (status),
        .irq        (irq)
    );

endmodule

// File: tb/tb_vdp_cpu_port.sv
// Scoreboard bench for vdp_cpu_port: expected VRAM accesses are queued as
// strobes are driven and matched when vram_req rises.
module tb_vdp_cpu_port;

    localparam int ADDR_W = 14;

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } acc_t;

    logic              pxclk = 1'b0;
    logic              reset;
    logic              cpu_wr, cpu_rd, cpu_mode;
    logic [7:0]        cpu_din;
    logic [7:0]        cpu_dout;
    logic              cpu_wait;
    logic [ADDR_W-1:0] vram_addr;
    logic [7:0]        vram_wdata;
    logic              vram_we, vram_req;
    logic              vram_ack;
    logic [7:0]        vram_rdata;
    logic              vblank_set, coll_set, fifth_set;
    logic [4:0]        fifth_num;
    logic [63:0]       regs;
    logic              irq;

    acc_t       exp_q[$];
    int         n_chk = 0;
    int         n_pass = 0;
    int         acc_cnt = 0;
    int         ack_delay = 0;
    logic [7:0] rd_data = 8'h00;

    vdp_cpu_port #(.ADDR_W(ADDR_W)) dut (
        .pxclk      (pxclk),
        .reset      (reset),
        .cpu_wr     (cpu_wr),
        .cpu_rd     (cpu_rd),
        .cpu_mode   (cpu_mode),
        .cpu_din    (cpu_din),
        .cpu_dout   (cpu_dout),
        .cpu_wait   (cpu_wait),
        .vram_addr  (vram_addr),
        .vram_wdata (vram_wdata),
        .vram_we    (vram_we),
        .vram_req   (vram_req),
        .vram_ack   (vram_ack),
        .vram_rdata (vram_rdata),
        .vblank_set (vblank_set),
        .coll_set   (coll_set),
        .fifth_set  (fifth_set),
        .fifth_num  (fifth_num),
        .regs       (regs),
        .irq        (irq)
    );

    always #5 pxclk = ~pxclk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Called at posedge+1; returns at the next posedge+1 with the strobe consumed.
    task automatic bus(input logic wr, input logic rd, input logic mode, input logic [7:0] d);
        cpu_wr = wr; cpu_rd = rd; cpu_mode = mode; cpu_din = d;
        @(posedge pxclk); #1;
        cpu_wr = 1'b0; cpu_rd = 1'b0;
    endtask

    task automatic pulse(input logic v, input logic c, input logic f, input logic [4:0] num);
        vblank_set = v; coll_set = c; fifth_set = f; fifth_num = num;
        @(posedge pxclk); #1;
        vblank_set = 1'b0; coll_set = 1'b0; fifth_set = 1'b0;
    endtask

    task automatic push(input logic we, input logic [ADDR_W-1:0] a, input logic [7:0] d);
        acc_t e;
        e.we = we; e.addr = a; e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (cpu_wait && n < 50) begin
            @(posedge pxclk); #1;
            n++;
        end
        check("idle", cpu_wait, 1'b0);
    endtask

    // VRAM responder and access monitor.
    initial begin
        logic              req_prev;
        logic [ADDR_W-1:0] hold_a;
        int                wcnt;
        acc_t              e;
        req_prev = 1'b0; hold_a = '0; wcnt = 0;
        vram_ack = 1'b0; vram_rdata = 8'h00;
        forever begin
            @(negedge pxclk);
            vram_ack = 1'b0;
            if (vram_req && !req_prev) begin
                acc_cnt++;
                if (exp_q.size() == 0) begin
                    check("acc_expected", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check("acc_we", vram_we, e.we);
                    check("acc_addr", vram_addr, e.addr);
                    if (e.we) check("acc_wdata", vram_wdata, e.data);
                end
                hold_a = vram_addr;
            end else if (vram_req) begin
                check("acc_hold", vram_addr, hold_a);
            end
            if (vram_req) begin
                if (wcnt == ack_delay) begin
                    vram_ack = 1'b1;
                    vram_rdata = rd_data;
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
            req_prev = vram_req;
        end
    end

    initial begin
        int acc0;
        reset = 1'b1; cpu_wr = 1'b0; cpu_rd = 1'b0; cpu_mode = 1'b0; cpu_din = 8'h00;
        vblank_set = 1'b0; coll_set = 1'b0; fifth_set = 1'b0; fifth_num = 5'd0;
        repeat (3) @(posedge pxclk);
        #1;
        check("rst_dout", cpu_dout, 8'h00);
        check("rst_wait", cpu_wait, 1'b0);
        check("rst_req", vram_req, 1'b0);
        check("rst_we", vram_we, 1'b0);
        check("rst_vaddr", vram_addr, 14'h0000);
        check("rst_regs", regs, 64'h0);
        check("rst_irq", irq, 1'b0);
        reset = 1'b0;
        @(posedge pxclk); #1;

        // Write address setup, then data writes at 0x0100 and 0x0101.
        bus(1, 0, 1, 8'h00);
        bus(1, 0, 1, 8'h41);
        check("setup_no_req", vram_req, 1'b0);
        push(1, 14'h0100, 8'hAB);
        bus(1, 0, 0, 8'hAB);
        check("wr_req_rise", vram_req, 1'b1);
        check("wr_wait_rise", cpu_wait, 1'b1);
        wait_idle();
        push(1, 14'h0101, 8'hCD);
        bus(1, 0, 0, 8'hCD);
        wait_idle();

        // Read setup with prefetch, then two data reads.
        rd_data = 8'h5A;
        push(0, 14'h0034, 8'h00);
        bus(1, 0, 1, 8'h34);
        bus(1, 0, 1, 8'h00);
        wait_idle();
        rd_data = 8'h77;
        push(0, 14'h0035, 8'h00);
        bus(0, 1, 0, 8'h00);
        check("rd_dout0", cpu_dout, 8'h5A);
        wait_idle();
        rd_data = 8'h11;
        push(0, 14'h0036, 8'h00);
        bus(0, 1, 0, 8'h00);
        check("rd_dout1", cpu_dout, 8'h77);
        wait_idle();

        // Register write, vblank interrupt and status read.
        bus(1, 0, 1, 8'h20);
        bus(1, 0, 1, 8'h81);
        check("reg_r1", regs[15:8], 8'h20);
        check("reg_r0", regs[7:0], 8'h00);
        pulse(1, 0, 0, 5'd0);
        check("irq_lag", irq, 1'b0);
        @(posedge pxclk); #1;
        check("irq_set", irq, 1'b1);
        bus(0, 1, 1, 8'h00);
        check("stat_f", cpu_dout, 8'h80);
        check("irq_hold", irq, 1'b1);
        @(posedge pxclk); #1;
        check("irq_clr", irq, 1'b0);

        // Address wrap at the top of VRAM.
        bus(1, 0, 1, 8'hFF);
        bus(1, 0, 1, 8'h7F);
        push(1, 14'h3FFF, 8'h11);
        bus(1, 0, 0, 8'h11);
        wait_idle();
        push(1, 14'h0000, 8'h22);
        bus(1, 0, 0, 8'h22);
        wait_idle();

        // Slow ack: second write dropped while busy.
        bus(1, 0, 1, 8'h00);
        bus(1, 0, 1, 8'h42);
        ack_delay = 5;
        acc0 = acc_cnt;
        push(1, 14'h0200, 8'h33);
        bus(1, 0, 0, 8'h33);
        check("busy_wait0", cpu_wait, 1'b1);
        bus(1, 0, 0, 8'h44);
        for (int i = 0; i < 3; i++) begin
            check("busy_wait", cpu_wait, 1'b1);
            @(posedge pxclk); #1;
        end
        wait_idle();
        check("busy_one_acc", acc_cnt - acc0, 1);
        ack_delay = 0;
        push(1, 14'h0201, 8'h55);
        bus(1, 0, 0, 8'h55);
        wait_idle();

        // Fifth-sprite capture and set-beats-clear on status read.
        pulse(0, 0, 1, 5'd3);
        pulse(0, 0, 1, 5'd7);
        coll_set = 1'b1;
        bus(0, 1, 1, 8'h00);
        coll_set = 1'b0;
        check("stat_5s", cpu_dout, 8'h43);
        bus(0, 1, 1, 8'h00);
        check("stat_coll", cpu_dout, 8'h23);
        bus(0, 1, 1, 8'h00);
        check("stat_clr", cpu_dout, 8'h03);

        // Write and read together: write wins, dout untouched.
        push(1, 14'h0202, 8'h66);
        bus(1, 1, 0, 8'h66);
        check("wr_rd_dout", cpu_dout, 8'h03);
        wait_idle();

        // Reset in the middle of an access.
        ack_delay = 3;
        push(1, 14'h0203, 8'h77);
        bus(1, 0, 0, 8'h77);
        check("mid_req", vram_req, 1'b1);
        reset = 1'b1;
        @(posedge pxclk); #1;
        reset = 1'b0;
        check("mid_rst_req", vram_req, 1'b0);
        check("mid_rst_wait", cpu_wait, 1'b0);
        check("mid_rst_regs", regs, 64'h0);
        repeat (5) @(posedge pxclk);
        #1;
        check("mid_rst_idle", vram_req, 1'b0);
        check("sb_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
